// File: rtl/ppbuf_read_ctrl_if.sv
// Read-side bus of the interleaver ping-pong buffer: write-done handshake, RAM read port and serial output.
// Optional PPRC_UNDERRUN_CNT_EN adds the underrun_cnt output.
interface ppbuf_read_ctrl_if #(
  parameter int unsigned IDX_W = 8
);
  logic             wr_done;
  logic             wr_bank;
  logic             q;
  logic             ready_in;
  logic [IDX_W:0]   rdaddress;
  logic             rd_en;
  logic             data_out;
  logic             valid_out;
  logic             sof;
  logic             eof;
  logic [1:0]       bank_full;
  logic             overflow;
`ifdef PPRC_UNDERRUN_CNT_EN
  logic [15:0]      underrun_cnt;
`endif

  modport master (
    input  wr_done, wr_bank, q, ready_in,
    output rdaddress, rd_en, data_out, valid_out, sof, eof, bank_full, overflow
`ifdef PPRC_UNDERRUN_CNT_EN
    , output underrun_cnt
`endif
  );

  modport slave (
    output wr_done, wr_bank, q, ready_in,
    input  rdaddress, rd_en, data_out, valid_out, sof, eof, bank_full, overflow
`ifdef PPRC_UNDERRUN_CNT_EN
    , input underrun_cnt
`endif
  );
endinterface

// File: rtl/ppbuf_read_ctrl.sv
// Ping-pong buffer read scheduler: bank full tracking, sequential RAM reads, 2-entry skid for read latency.
// Optional feature macro: PPRC_UNDERRUN_CNT_EN (in-block underrun counter).
module ppbuf_read_ctrl #(
  parameter int unsigned NCBPS = 192,
  parameter int unsigned IDX_W = 8
) (
  input logic               clk,
  input logic               reset,
  ppbuf_read_ctrl_if.master bus
);
  typedef enum logic {IDLE, READ} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCBPS - 1);

  state_t           state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   addr_q, addr_d;
  logic [1:0]       full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             clr_pend_q, clr_pend_d;
  logic             clr_bank_q, clr_bank_d;
  logic             infl_q, infl_sof_q, infl_eof_q;
  logic [2:0]       mem_q [2];
  logic             rptr_q, wptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             issue, pop, push, room;
  logic [2:0]       used;
  logic [1:0]       set_v, clr_v;
  logic [2:0]       head;

  assign push = infl_q;
  assign head = mem_q[rptr_q];

  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    idx_d      = idx_q;
    issue      = 1'b0;
    pop        = (occ_q != 2'd0) && bus.ready_in;
    // An entry popping this cycle frees its slot now, keeping 1 bit/cycle.
    used       = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    room       = (used < 3'd2);
    unique case (state_q)
      // The first read is issued on the IDLE->READ transition to meet the t+1 read latency.
      IDLE: if (full_q[rd_bank_q]) begin
        state_d = READ;
        issue   = room;
      end
      READ: issue = room;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (idx_q == LAST) begin
        idx_d     = '0;
        rd_bank_d = ~rd_bank_q;
        state_d   = full_q[~rd_bank_q] ? READ : IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    addr_d     = issue ? {rd_bank_q, idx_q} : addr_q;
    set_v      = '0;
    clr_v      = '0;
    if (bus.wr_done) set_v[bus.wr_bank] = 1'b1;
    if (clr_pend_q)  clr_v[clr_bank_q]  = 1'b1;
    full_d     = (full_q & ~clr_v) | set_v;
    ovf_d      = ovf_q | (bus.wr_done & full_q[bus.wr_bank]);
    clr_pend_d = issue && (idx_q == LAST);
    clr_bank_d = rd_bank_q;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      idx_q      <= '0;
      addr_q     <= '0;
      full_q     <= '0;
      ovf_q      <= 1'b0;
      clr_pend_q <= 1'b0;
      clr_bank_q <= 1'b0;
      infl_q     <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eof_q <= 1'b0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      clr_pend_q <= clr_pend_d;
      clr_bank_q <= clr_bank_d;
      infl_q     <= issue;
      infl_sof_q <= issue && (idx_q == '0);
      infl_eof_q <= issue && (idx_q == LAST);
      occ_q      <= occ_d;
      if (push) begin
        mem_q[wptr_q] <= {bus.q, infl_sof_q, infl_eof_q};
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  assign bus.rd_en     = issue;
  assign bus.rdaddress = addr_d;
  assign bus.valid_out = (occ_q != 2'd0);
  assign bus.data_out  = bus.valid_out & head[2];
  assign bus.sof       = bus.valid_out & head[1];
  assign bus.eof       = bus.valid_out & head[0];
  assign bus.bank_full = full_q;
  assign bus.overflow  = ovf_q;

`ifdef PPRC_UNDERRUN_CNT_EN
  logic        in_blk_q, in_blk_d;
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    in_blk_d = in_blk_q;
    ucnt_d   = ucnt_q;
    if (pop && head[0])      in_blk_d = 1'b0;
    else if (pop && head[1]) in_blk_d = 1'b1;
    if (bus.ready_in && !bus.valid_out && in_blk_q && (ucnt_q != '1))
      ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_blk_q <= 1'b0;
      ucnt_q   <= '0;
    end else begin
      in_blk_q <= in_blk_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign bus.underrun_cnt = ucnt_q;
`endif
endmodule
